tick_scheduler: RTL and testbench
=================================

Name: tick_scheduler

Overview:
Shared timebase controller for the game logic. It owns the free-running 32-bit clkdiv counter and derives NCH independent single-cycle enable pulses ("ticks") from it, for example Pacman move, ghost move, sprite animation and blink. A start/pause/step/stop FSM sequences all channels together. A one-cycle write port sets each channel's period and enable. Consumers use tick[i] as a clock enable; no derived clocks leave this block.

Parameters:
NCH, 4, number of tick channels
PW, 24, width of period registers and per-channel down-counters
DEF_PERIOD, 24'd1_000_000, reset period loaded into every channel

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  pulse; IDLE->RUN, PAUSED->RUN
pause  in  1  pulse; RUN->PAUSED
step  in  1  pulse; PAUSED->STEP (one tick burst)
stop  in  1  pulse; any state->IDLE
wr_en  in  1  config write strobe
wr_ch  in  $clog2(NCH)  channel index for the write
wr_period  in  PW  new period in clk cycles
wr_chen  in  1  new channel enable
tick  out  NCH  registered one-cycle enable pulses
clkdiv  out  32  free-running counter
frame_cnt  out  16  count of tick[0] pulses
running  out  1  state==RUN
paused  out  1  state==PAUSED

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; clkdiv=0; tick=0; frame_cnt=0; period[i]=DEF_PERIOD; en[i]=1; cnt[i]=DEF_PERIOD-1. Reset mid-operation aborts everything immediately.
- clkdiv: +1 on every clk edge in every state. Wraps 0xFFFF_FFFF->0.
- Effective period: Pe = period[i]. A value of 0 is treated as 1.
- Input priority, evaluated each edge: stop > pause > start > step. Inputs that are illegal for the current state are ignored.
- FSM states: IDLE, RUN, PAUSED, STEP.
  - IDLE: cnt[i] is continuously reloaded to Pe-1; tick=0. start -> RUN and frame_cnt is cleared.
  - RUN: start is ignored. For each channel with en[i]=1: if cnt[i]==0, set tick[i]=1 and reload cnt[i]=Pe-1; otherwise decrement cnt[i] and set tick[i]=0. pause -> PAUSED.
  - PAUSED: all cnt values hold; tick=0. start -> RUN, resuming from the held counts. step -> STEP.
  - STEP: lasts exactly 1 cycle. At its closing edge, tick[i]=en[i] and cnt[i] reloads to Pe-1; the next state is PAUSED.
  - stop from any state -> IDLE with tick=0.
- Tick timing: let start be sampled at edge E0. The first tick[i] is high in the cycle following edge E0+Pe, then repeats every Pe cycles. With Pe=1, tick stays high continuously.
- Step timing: step sampled at edge E -> STEP during the cycle after E -> tick high during the cycle after E+1.
- Disabled channel: tick[i]=0 from the next cycle; cnt[i] holds (in IDLE it still reloads).
- Config write:
  - Accepted in any state at the edge where wr_en=1. Updates period[wr_ch] and en[wr_ch].
  - In RUN, a new period takes effect at the channel's next reload; the current countdown is not truncated.
  - If the write lands on the same edge as that channel's reload, the reload uses the old period.
  - wr_ch >= NCH: write ignored.
- frame_cnt: +1 on each cycle where tick[0]=1. 16-bit wrap. Cleared only by reset and by IDLE->RUN.
- running and paused: combinational decode of the state register.
- Size target: roughly 150-250 lines of RTL.

Test Plan:
- Reset and default run: rst low 3 cycles, then wr ch0 period=4, start -> first tick[0] four cycles after the start edge, then every 4 cycles. clkdiv counts from 0. After 10 ticks, frame_cnt=10.
- Pause and resume: ch1 period=5. pause 2 cycles after a tick[1], hold 20 cycles, then start -> no ticks while paused. Next tick[1] arrives 3 cycles after the start edge, so counts are preserved.
- Single step: in PAUSED with en=4'b1011, pulse step -> tick=4'b1011 for exactly one cycle, two cycles after step. State returns to PAUSED.
- Edge periods and mid-run write: period=0 and period=1 -> tick every cycle. While running with period=8, write period=3 -> the current 8-cycle interval completes, then ticks every 3 cycles. Write with wr_ch out of range -> no change.
- Priority and stop: pulse stop+pause+start together in RUN -> IDLE, tick=0. Pulse pause+start in PAUSED -> stays PAUSED. Drive clkdiv near 0xFFFF_FFFF by forcing, or run long enough -> wraps to 0.
- Async reset mid-RUN: drop rst between edges -> tick, clkdiv and frame_cnt are 0 immediately, without waiting for a clk edge. State returns to IDLE and periods revert to DEF_PERIOD.

Source files
------------

// File: rtl/tick_scheduler.sv
// tick_scheduler: shared timebase for the game logic.
//
// This block owns a free-running 32-bit clkdiv counter. It also produces NCH independent
// single-cycle enable pulses (ticks), one per channel, each with its own programmable period.
// A start/pause/step/stop FSM drives all channels together. Consumers use tick[i] as a
// clock enable. No derived clocks leave this block.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-low reset
//   start      pulse: IDLE->RUN, PAUSED->RUN (resumes from held counts)
//   pause      pulse: RUN->PAUSED
//   step       pulse: PAUSED->STEP (one tick burst, then back to PAUSED)
//   stop       pulse: any state->IDLE
//   wr_en      config write strobe
//   wr_ch      channel index for the write (indices >= NCH are ignored)
//   wr_period  new period in clk cycles (0 behaves as 1)
//   wr_chen    new channel enable
//   tick       registered one-cycle enable pulses, one per channel
//   clkdiv     free-running counter, increments every cycle in every state
//   frame_cnt  count of cycles with tick[0] high; cleared on reset and on IDLE->RUN
//   running    state is RUN
//   paused     state is PAUSED
module tick_scheduler #(
   parameter int unsigned    NCH        = 4,
   parameter int unsigned    PW         = 24,
   parameter logic [PW-1:0]  DEF_PERIOD = 24'd1_000_000,
   localparam int unsigned   CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           pause,
   input  logic           step,
   input  logic           stop,
   input  logic           wr_en,
   input  logic [CW-1:0]  wr_ch,
   input  logic [PW-1:0]  wr_period,
   input  logic           wr_chen,
   output logic [NCH-1:0] tick,
   output logic [31:0]    clkdiv,
   output logic [15:0]    frame_cnt,
   output logic           running,
   output logic           paused
);

   typedef enum logic [1:0] {StIdle, StRun, StPaused, StStep} state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   period_q [NCH];
   logic [NCH-1:0]  en_q;
   logic [PW-1:0]   cnt_q [NCH];
   logic [PW-1:0]   cnt_d [NCH];
   logic [NCH-1:0]  tick_q, tick_d;
   logic [31:0]     clkdiv_q;
   logic [15:0]     frame_q, frame_d;

   // Reload value for a countdown: Pe-1, where a programmed period of 0 acts as 1.
   function automatic logic [PW-1:0] reload_val(input logic [PW-1:0] p);
      return (p == '0) ? '0 : p - PW'(1);
   endfunction

   // Next-state logic. The highest-priority asserted command wins even when it is
   // illegal in the current state. In that case nothing happens, and a lower-priority
   // command does not get to act instead.
   always_comb begin
      state_d = state_q;
      if (stop) begin
         state_d = StIdle;
      end else if (pause) begin
         if (state_q == StRun) state_d = StPaused;
      end else if (start) begin
         if (state_q == StIdle || state_q == StPaused) state_d = StRun;
      end else if (step) begin
         if (state_q == StPaused) state_d = StStep;
      end
      // STEP always lasts exactly one cycle unless stop pre-empts it.
      if (state_q == StStep && !stop) state_d = StPaused;
   end

   // Per-channel countdowns and tick generation. These are keyed on the current state,
   // so the edge that leaves RUN still performs one RUN update.
   always_comb begin
      tick_d = '0;
      for (int i = 0; i < int'(NCH); i++) begin
         cnt_d[i] = cnt_q[i];
         case (state_q)
            StIdle: begin
               cnt_d[i] = reload_val(period_q[i]);
            end
            StRun: begin
               if (en_q[i]) begin
                  if (cnt_q[i] == '0) begin
                     tick_d[i] = 1'b1;
                     // The reload reads period_q before any write on this edge lands.
                     cnt_d[i]  = reload_val(period_q[i]);
                  end else begin
                     cnt_d[i] = cnt_q[i] - PW'(1);
                  end
               end
            end
            StStep: begin
               tick_d[i] = en_q[i];
               cnt_d[i]  = reload_val(period_q[i]);
            end
            default: begin
               cnt_d[i] = cnt_q[i];
            end
         endcase
      end
      if (stop) tick_d = '0;
   end

   always_comb begin
      frame_d = frame_q + {15'd0, tick_q[0]};
      if (state_q == StIdle && state_d == StRun) frame_d = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         clkdiv_q <= '0;
         tick_q   <= '0;
         frame_q  <= '0;
         for (int i = 0; i < int'(NCH); i++) cnt_q[i] <= reload_val(DEF_PERIOD);
      end else begin
         state_q  <= state_d;
         clkdiv_q <= clkdiv_q + 32'd1;
         tick_q   <= tick_d;
         frame_q  <= frame_d;
         for (int i = 0; i < int'(NCH); i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // Config registers. An index with no matching channel simply matches no i, so the write
   // is dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en_q <= '1;
         for (int i = 0; i < int'(NCH); i++) period_q[i] <= DEF_PERIOD;
      end else if (wr_en) begin
         for (int i = 0; i < int'(NCH); i++) begin
            if (wr_ch == CW'(i)) begin
               period_q[i] <= wr_period;
               en_q[i]     <= wr_chen;
            end
         end
      end
   end

   assign tick      = tick_q;
   assign clkdiv    = clkdiv_q;
   assign frame_cnt = frame_q;
   assign running   = (state_q == StRun);
   assign paused    = (state_q == StPaused);

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler.
//
// The stimulus process drives directed sequences. For every tick pulse it schedules, it
// pushes the hand-computed expectation onto a scoreboard queue: edge index, pattern and
// frame count. A separate monitor pops and compares on each cycle where tick is non-zero.
// Edge index k means the k-th rising edge since reset release, which clkdiv must equal.
module tb_tick_scheduler;

   localparam int unsigned NCH = 5;
   localparam int unsigned PW  = 24;
   localparam int unsigned CW  = $clog2(NCH);

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0, pause = 1'b0, step = 1'b0, stop = 1'b0;
   logic           wr_en = 1'b0, wr_chen = 1'b0;
   logic [CW-1:0]  wr_ch = '0;
   logic [PW-1:0]  wr_period = '0;
   logic [NCH-1:0] tick;
   logic [31:0]    clkdiv;
   logic [15:0]    frame_cnt;
   logic           running, paused;

   typedef struct {
      int             at;
      logic [NCH-1:0] pat;
      int             fc;
      bit             chk_fc;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   now    = 0;

   tick_scheduler #(
      .NCH        (NCH),
      .PW         (PW),
      .DEF_PERIOD (24'd20)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pause     (pause),
      .step      (step),
      .stop      (stop),
      .wr_en     (wr_en),
      .wr_ch     (wr_ch),
      .wr_period (wr_period),
      .wr_chen   (wr_chen),
      .tick      (tick),
      .clkdiv    (clkdiv),
      .frame_cnt (frame_cnt),
      .running   (running),
      .paused    (paused)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         now++;
      end
   endtask

   // The write is sampled at the next edge. On return, now equals that edge.
   task automatic wr(input int ch, input int per, input bit en);
      wr_en     = 1'b1;
      wr_ch     = CW'(ch);
      wr_period = PW'(per);
      wr_chen   = en;
      cyc(1);
      wr_en     = 1'b0;
   endtask

   task automatic push(input int at, input logic [NCH-1:0] pat, input int fc, input bit chk_fc);
      exp_t e;
      e.at     = at;
      e.pat    = pat;
      e.fc     = fc;
      e.chk_fc = chk_fc;
      sb.push_back(e);
   endtask

   // Monitor: every cycle that presents a tick must match the head of the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (tick !== '0) begin
            if (sb.size() == 0) begin
               chk("unexpected_tick", 32'(tick), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("tick_edge", clkdiv, 32'(e.at));
               chk("tick_pattern", 32'(tick), 32'(e.pat));
               if (e.chk_fc) chk("frame_cnt_at_tick", 32'(frame_cnt), 32'(e.fc));
            end
         end
      end
   end

   initial begin
      // Reset held for 3 cycles.
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tick", 32'(tick), 32'd0);
      chk("reset_clkdiv", clkdiv, 32'd0);
      chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("reset_running", 32'(running), 32'd0);
      chk("reset_paused", 32'(paused), 32'd0);
      rst = 1'b1;
      now = 0;

      // Default run: ch0 period 4, other channels disabled. Start at edge 6.
      for (int ch = 1; ch < 5; ch++) wr(ch, 20, 1'b0);
      wr(0, 4, 1'b1);
      start = 1'b1; cyc(1); start = 1'b0;
      chk("running_after_start", 32'(running), 32'd1);
      chk("paused_after_start", 32'(paused), 32'd0);
      for (int k = 0; k < 10; k++) push(6 + 4 * (k + 1), 5'b00001, k, 1'b1);
      cyc(41);
      chk("frame_cnt_after_10", 32'(frame_cnt), 32'd10);
      stop = 1'b1; cyc(1); stop = 1'b0;
      chk("running_after_stop", 32'(running), 32'd0);

      // Pause and resume: ch1 period 5. Start at 51 gives ticks at 56 and 61. Pause at 63
      // holds cnt=2, so a restart at 84 gives the next tick at 87.
      wr(0, 4, 1'b0);
      wr(1, 5, 1'b1);
      start = 1'b1; cyc(1); start = 1'b0;
      push(56, 5'b00010, 0, 1'b0);
      push(61, 5'b00010, 0, 1'b0);
      cyc(11);
      pause = 1'b1; cyc(1); pause = 1'b0;
      chk("paused_after_pause", 32'(paused), 32'd1);
      chk("running_after_pause", 32'(running), 32'd0);
      chk("frame_cnt_cleared_on_start", 32'(frame_cnt), 32'd0);
      cyc(20);
      chk("still_paused", 32'(paused), 32'd1);
      push(87, 5'b00010, 0, 1'b0);
      push(92, 5'b00010, 0, 1'b0);
      start = 1'b1; cyc(1); start = 1'b0;
      chk("running_after_resume", 32'(running), 32'd1);
      cyc(9);
      pause = 1'b1; cyc(1); pause = 1'b0;

      // Single step with en=01011: step sampled at 97, tick burst at 98.
      wr(0, 4, 1'b1);
      wr(3, 7, 1'b1);
      push(98, 5'b01011, 0, 1'b0);
      step = 1'b1; cyc(1); step = 1'b0;
      chk("step_state_not_paused", 32'(paused), 32'd0);
      chk("step_state_not_running", 32'(running), 32'd0);
      cyc(1);
      chk("paused_after_step", 32'(paused), 32'd1);
      cyc(3);
      pause = 1'b1; start = 1'b1; cyc(1); pause = 1'b0; start = 1'b0;
      chk("pause_start_in_paused", 32'(paused), 32'd1);
      chk("frame_cnt_counts_step", 32'(frame_cnt), 32'd1);

      // Edge periods and a mid-run write: ch0 period 0, ch1 period 1, ch3 period 8. Start at
      // 107. ch3 is rewritten to 3 at 110, so it ticks at 115, then at 118 and 121.
      stop = 1'b1; cyc(1); stop = 1'b0;
      wr(0, 0, 1'b1);
      wr(1, 1, 1'b1);
      wr(3, 8, 1'b1);
      start = 1'b1; cyc(1); start = 1'b0;
      for (int e = 108; e <= 122; e++)
         push(e, (e == 115 || e == 118 || e == 121) ? 5'b01011 : 5'b00011, e - 108, 1'b1);
      cyc(2);
      wr(3, 3, 1'b1);
      wr(5, 2, 1'b0);
      cyc(11);
      stop = 1'b1; cyc(1); stop = 1'b0;
      chk("tick_after_stop", 32'(tick), 32'd0);
      chk("idle_after_stop", 32'(running), 32'd0);

      // Priority: stop+pause+start together in RUN -> IDLE.
      start = 1'b1; cyc(1); start = 1'b0;
      push(125, 5'b00011, 0, 1'b1);
      push(126, 5'b00011, 1, 1'b1);
      push(127, 5'b01011, 2, 1'b1);
      cyc(3);
      stop = 1'b1; pause = 1'b1; start = 1'b1; cyc(1);
      stop = 1'b0; pause = 1'b0; start = 1'b0;
      chk("prio_tick", 32'(tick), 32'd0);
      chk("prio_running", 32'(running), 32'd0);
      chk("prio_paused", 32'(paused), 32'd0);
      cyc(3);

      // Async reset mid-RUN, applied between edges.
      start = 1'b1; cyc(1); start = 1'b0;
      push(133, 5'b00011, 0, 1'b1);
      push(134, 5'b00011, 1, 1'b1);
      push(135, 5'b01011, 2, 1'b1);
      push(136, 5'b00011, 3, 1'b1);
      cyc(4);
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk("async_tick", 32'(tick), 32'd0);
      chk("async_clkdiv", clkdiv, 32'd0);
      chk("async_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("async_running", 32'(running), 32'd0);
      chk("sb_drained_before_reset", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      now = 0;

      // Periods and enables revert to 20 / all-on: start at 1, ticks at 21 and 41.
      push(21, 5'b11111, 0, 1'b1);
      push(41, 5'b11111, 1, 1'b1);
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(41);
      stop = 1'b1; cyc(1); stop = 1'b0;
      cyc(2);
      chk("sb_drained_at_end", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
